// File: rtl/main_mem_ctrl.sv
// ============================================================================
//  Module   : main_mem_ctrl
//  Purpose  : Clocked main-memory model with req/ready handshake, serving
//             128-bit block reads/writes and 32-bit word writes after a
//             fixed LATENCY. Optional MEM_STATS_EN adds read/write counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module main_mem_ctrl #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memReq,
   input  logic              isMemRead,
   input  logic              isWordWrite,
   input  logic [ADDR_W-1:0] memAddress,
   input  logic [127:0]      memWriteData,
   output logic [127:0]      memReadData,
   output logic              memReady,
   output logic              isBusy
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]       readCount,
   output logic [15:0]       writeCount
`endif
);

   localparam int c_WIDX_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef logic [31:0] mem_t [DEPTH];

   // Power-up image: word i holds i; reset never touches the array.
   function automatic mem_t f_mem_init();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
      return m;
   endfunction

   mem_t                r_mem = f_mem_init();
   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic [c_WIDX_W-1:0] r_addr;
   logic [127:0]        r_wdata;
   logic                r_is_read;
   logic                r_is_word;
   logic [127:0]        r_rdata;
   logic [127:0]        w_block;
   logic                w_accept;
   logic                w_commit;
   logic                w_unused_lsb;

   assign w_unused_lsb = ^memAddress[1:0];
   assign w_accept     = (r_state == S_IDLE) && memReq;
   // Access happens on the edge leaving the last BUSY cycle, unless reset aborts it.
   assign w_commit     = (r_state == S_BUSY) && (r_cnt == 4'd0) && !reset;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (memReq) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = 4'(LATENCY - 1);
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) w_state_nxt = S_DONE;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 128'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_commit && r_is_read) r_rdata <= w_block;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr    <= memAddress[ADDR_W-1:2];
         r_wdata   <= memWriteData;
         r_is_read <= isMemRead;
         r_is_word <= isWordWrite;
      end
   end

   always_comb begin
      w_block = 128'd0;
      for (int w = 0; w < 4; w++)
         w_block[127-32*w -: 32] = r_mem[{r_addr[c_WIDX_W-1:2], 2'(w)}];
   end

   always_ff @(posedge clk) begin
      if (w_commit && !r_is_read) begin
         if (r_is_word) begin
            r_mem[r_addr] <= r_wdata[31:0];
         end else begin
            for (int w = 0; w < 4; w++)
               r_mem[{r_addr[c_WIDX_W-1:2], 2'(w)}] <= r_wdata[127-32*w -: 32];
         end
      end
   end

   assign memReadData = r_rdata;
   assign memReady    = (r_state == S_DONE);
   assign isBusy      = (r_state != S_IDLE);

`ifdef MEM_STATS_EN
   logic [15:0] r_rd_cnt;
   logic [15:0] r_wr_cnt;

   // Counts become visible in the DONE cycle and stick at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_cnt <= 16'd0;
         r_wr_cnt <= 16'd0;
      end else if (w_commit) begin
         if (r_is_read && (r_rd_cnt != 16'hFFFF))  r_rd_cnt <= r_rd_cnt + 16'd1;
         if (!r_is_read && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
      end
   end

   assign readCount  = r_rd_cnt;
   assign writeCount = r_wr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
// ============================================================================
//  Module   : tb_main_mem_ctrl
//  Purpose  : Self-checking bench for main_mem_ctrl against an array model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_main_mem_ctrl;

   localparam int c_LAT   = 4;
   localparam int c_DEPTH = 256;

   logic         clk = 1'b0;
   logic         reset;
   logic         memReq;
   logic         isMemRead;
   logic         isWordWrite;
   logic [9:0]   memAddress;
   logic [127:0] memWriteData;
   logic [127:0] memReadData;
   logic         memReady;
   logic         isBusy;
`ifdef MEM_STATS_EN
   logic [15:0]  readCount;
   logic [15:0]  writeCount;
`endif

   main_mem_ctrl #(.LATENCY(c_LAT), .DEPTH(c_DEPTH)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .memReq       (memReq),
      .isMemRead    (isMemRead),
      .isWordWrite  (isWordWrite),
      .memAddress   (memAddress),
      .memWriteData (memWriteData),
      .memReadData  (memReadData),
      .memReady     (memReady),
      .isBusy       (isBusy)
`ifdef MEM_STATS_EN
      ,
      .readCount    (readCount),
      .writeCount   (writeCount)
`endif
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_err = 0;
   logic [31:0]  m_mem [c_DEPTH];
   logic [127:0] m_last_rd;
   int           m_nrd;
   int           m_nwr;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] m_block(input logic [9:0] addr);
      logic [127:0] b;
      for (int w = 0; w < 4; w++) b[127-32*w -: 32] = m_mem[{addr[9:4], 2'(w)}];
      return b;
   endfunction

   task automatic chk_stats();
`ifdef MEM_STATS_EN
      chk("readCount",  {112'd0, readCount},  128'(m_nrd));
      chk("writeCount", {112'd0, writeCount}, 128'(m_nwr));
`endif
   endtask

   // One full transaction: drive, then watch a window twice the latency for
   // exactly one ready pulse at T+LAT+1, busy span, and read data.
   task automatic do_op(input bit rd, input bit wd, input logic [9:0] addr,
                        input logic [127:0] wdata, input bit inject, input bit rst_mid);
      logic [127:0] exp_rd;
      @(negedge clk);
      memReq = 1'b1; isMemRead = rd; isWordWrite = wd;
      memAddress = addr; memWriteData = wdata;
      @(posedge clk);
      @(negedge clk);
      memReq = 1'b0; isMemRead = 1'($urandom); isWordWrite = 1'($urandom);
      memAddress = 10'($urandom); memWriteData = {$urandom, $urandom, $urandom, $urandom};
      exp_rd = m_block(addr);
      if (rst_mid) begin
         m_last_rd = 128'd0; m_nrd = 0; m_nwr = 0;
      end else if (rd) begin
         m_last_rd = exp_rd; m_nrd++;
      end else begin
         m_nwr++;
         if (wd) m_mem[addr[9:2]] = wdata[31:0];
         else for (int w = 0; w < 4; w++) m_mem[{addr[9:4], 2'(w)}] = wdata[127-32*w -: 32];
      end
      for (int k = 1; k <= 2*c_LAT + 4; k++) begin
         if (k > 1) @(negedge clk);
         chk("memReady", {127'd0, memReady}, {127'd0, (!rst_mid && k == c_LAT + 1)});
         chk("isBusy",   {127'd0, isBusy},   {127'd0, (rst_mid ? (k <= 2) : (k <= c_LAT + 1))});
         if (rd && !rst_mid && k == c_LAT + 1) chk("rdata", memReadData, exp_rd);
         if (inject && k == 2) begin
            memReq = 1'b1; isMemRead = 1'b0; isWordWrite = 1'b1;
            memAddress = addr ^ 10'h100; memWriteData = {4{32'hBAD0BAD0}};
         end
         if (inject && k == 3) memReq = 1'b0;
         if (rst_mid && k == 2) reset = 1'b1;
         if (rst_mid && k == 3) reset = 1'b0;
      end
      chk("rdata_hold", memReadData, m_last_rd);
      chk_stats();
   endtask

   initial begin
      for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 32'(i);
      m_last_rd = 128'd0; m_nrd = 0; m_nwr = 0;
      reset = 1'b1; memReq = 1'b0; isMemRead = 1'b0; isWordWrite = 1'b0;
      memAddress = 10'd0; memWriteData = 128'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", {127'd0, memReady}, 128'd0);
      chk("rst_busy",  {127'd0, isBusy},   128'd0);
      chk("rst_rdata", memReadData, 128'd0);
      chk_stats();

      do_op(1'b1, 1'b0, 10'h040, 128'd0, 1'b0, 1'b0);
      chk("plan_read", m_last_rd, {32'd16, 32'd17, 32'd18, 32'd19});
      do_op(1'b0, 1'b1, 10'h048, {96'd0, 32'hDEADBEEF}, 1'b0, 1'b0);
      do_op(1'b1, 1'b0, 10'h040, 128'd0, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 10'h3F0, 128'h0000_0001_0000_0002_0000_0003_0000_0004, 1'b0, 1'b0);
      do_op(1'b1, 1'b0, 10'h3F0, 128'd0, 1'b0, 1'b0);
      do_op(1'b1, 1'b0, 10'h080, 128'd0, 1'b1, 1'b0);
      do_op(1'b1, 1'b0, 10'h180, 128'd0, 1'b0, 1'b0);
      do_op(1'b0, 1'b0, 10'h0C0, {4{32'h5555AAAA}}, 1'b0, 1'b1);
      do_op(1'b1, 1'b0, 10'h0C0, 128'd0, 1'b0, 1'b0);

      // Reset and request in the same cycle: the request must be dropped.
      @(negedge clk);
      reset = 1'b1; memReq = 1'b1; isMemRead = 1'b1; memAddress = 10'h010;
      @(negedge clk);
      reset = 1'b0; memReq = 1'b0;
      m_last_rd = 128'd0; m_nrd = 0; m_nwr = 0;
      repeat (c_LAT + 3) begin
         chk("rstreq_busy",  {127'd0, isBusy},   128'd0);
         chk("rstreq_ready", {127'd0, memReady}, 128'd0);
         @(negedge clk);
      end

      for (int n = 0; n < 40; n++) begin
         logic       rd;
         logic       wd;
         logic [9:0] a;
         rd = 1'($urandom);
         wd = 1'($urandom);
         a  = 10'($urandom_range(0, 255));
         if (n % 8 == 7) a = 10'($urandom);
         do_op(rd, wd, a, {$urandom, $urandom, $urandom, $urandom},
               ($urandom_range(0, 5) == 0), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
